// File: rtl/dmem_pkg.sv
// Shared types and the request-legality rule for the data-memory responder.
package dmem_pkg;

    // Load/store access modes in RISC-V funct3 encoding.
    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } memFunct3E;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } dmemStateE;

    // Unsigned modes exist only for loads; any other unlisted code is illegal.
    function automatic logic is_legal(input logic [2:0] funct3, input logic we);
        logic legal;
        case (funct3)
            MEM_B, MEM_H, MEM_W: legal = 1'b1;
            MEM_BU, MEM_HU:      legal = ~we;
            default:             legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte mask / replicated write data, and load
// lane select with sign or zero extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byteOff,
    input  logic [31:0] wdata,
    input  logic [31:0] rawWord,
    output logic [3:0]  byteMask,
    output logic [31:0] laneWdata,
    output logic [31:0] rdata,
    output logic        misaligned
);

    logic [31:0] shifted;
    logic [7:0]  byteVal;
    logic [15:0] halfVal;

    always_comb begin
        byteMask  = 4'b1111;
        laneWdata = wdata;
        // funct3[1:0] gives the access size for stores; unsigned codes never reach a write.
        case (funct3[1:0])
            2'b00: begin
                byteMask  = 4'b0001 << byteOff;
                laneWdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                byteMask  = byteOff[1] ? 4'b1100 : 4'b0011;
                laneWdata = {2{wdata[15:0]}};
            end
            default: begin
                byteMask  = 4'b1111;
                laneWdata = wdata;
            end
        endcase
    end

    assign shifted = rawWord >> {byteOff, 3'b000};
    assign byteVal = shifted[7:0];
    assign halfVal = byteOff[1] ? rawWord[31:16] : rawWord[15:0];

    always_comb begin
        rdata = '0;
        case (funct3)
            MEM_B:   rdata = {{24{byteVal[7]}}, byteVal};
            MEM_H:   rdata = {{16{halfVal[15]}}, halfVal};
            MEM_W:   rdata = rawWord;
            MEM_BU:  rdata = {24'd0, byteVal};
            MEM_HU:  rdata = {16'd0, halfVal};
            default: rdata = '0;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        case (funct3)
            MEM_H, MEM_HU: misaligned = byteOff[0];
            MEM_W:         misaligned = (byteOff != 2'b00);
            default:       misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with programmable wait states and back-pressure.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned halfword/word accesses as errors.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter string       INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned AW      = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CntInit = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
    localparam logic        NoWait  = (LATENCY == 0);

    dmemStateE             stateQ, stateD;
    logic [3:0]            cntQ, cntD;
    logic                  weQ;
    logic [2:0]            funct3Q;
    logic [AW+1:0]         addrQ;
    logic [DATA_WIDTH-1:0] wdataQ;
    logic [DATA_WIDTH-1:0] rspRdataQ;
    logic                  rspErrQ;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    logic                  accept;
    logic                  enterResp;
    logic                  opWe;
    logic [2:0]            opFunct3;
    logic [AW+1:0]         opAddr;
    logic [DATA_WIDTH-1:0] opWdata;
    logic [AW-1:0]         wordIdx;
    logic [31:0]           rawWord;
    logic [3:0]            byteMask;
    logic [31:0]           laneWdata;
    logic [31:0]           loadData;
    logic                  misaligned;
    logic                  legal;

    assign req_ready = (stateQ == StIdle);
    assign rsp_valid = (stateQ == StResp);
    assign rsp_rdata = rspRdataQ;
    assign rsp_err   = rspErrQ;

    assign accept = req_ready && req_valid;

    // With zero wait states the commit edge is the accepting edge, so use the live request.
    always_comb begin
        if (stateQ == StIdle) begin
            opWe     = req_we;
            opFunct3 = req_funct3;
            opAddr   = req_addr[AW+1:0];
            opWdata  = req_wdata;
        end else begin
            opWe     = weQ;
            opFunct3 = funct3Q;
            opAddr   = addrQ;
            opWdata  = wdataQ;
        end
    end

    assign enterResp = (accept && NoWait) || ((stateQ == StWait) && (cntQ == 4'd0));
    assign wordIdx   = opAddr[AW+1:2];
    assign rawWord   = mem[wordIdx];

    dmem_lane_align uLaneAlign (
        .funct3     (opFunct3),
        .byteOff    (opAddr[1:0]),
        .wdata      (opWdata),
        .rawWord    (rawWord),
        .byteMask   (byteMask),
        .laneWdata  (laneWdata),
        .rdata      (loadData),
        .misaligned (misaligned)
    );

`ifdef DMEM_MISALIGN_TRAP_EN
    logic unusedAddrBits;
    assign unusedAddrBits = ^req_addr[31:AW+2];
    assign legal = is_legal(opFunct3, opWe) && !misaligned;
`else
    logic unusedAddrBits;
    assign unusedAddrBits = ^{req_addr[31:AW+2], misaligned};
    assign legal = is_legal(opFunct3, opWe);
`endif

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        case (stateQ)
            StIdle: begin
                if (req_valid) begin
                    stateD = NoWait ? StResp : StWait;
                    cntD   = CntInit;
                end
            end
            StWait: begin
                if (cntQ == 4'd0) begin
                    stateD = StResp;
                end else begin
                    cntD = cntQ - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ    <= StIdle;
            cntQ      <= 4'd0;
            weQ       <= 1'b0;
            funct3Q   <= 3'd0;
            addrQ     <= '0;
            wdataQ    <= '0;
            rspRdataQ <= '0;
            rspErrQ   <= 1'b0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            if (accept) begin
                weQ     <= req_we;
                funct3Q <= req_funct3;
                addrQ   <= req_addr[AW+1:0];
                wdataQ  <= req_wdata;
            end
            if (enterResp) begin
                rspErrQ   <= !legal;
                rspRdataQ <= (legal && !opWe) ? loadData : '0;
            end
        end
    end

    // RAM is not reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && enterResp && legal && opWe) begin
            for (int b = 0; b < 4; b++) begin
                if (byteMask[b]) begin
                    mem[wordIdx][8*b +: 8] <= laneWdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: byte-addressed reference model, randomized traffic,
// directed stall/reset/illegal cases.
module tb_dmem_responder;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    dmem_responder #(
        .DATA_WIDTH  (32),
        .DEPTH_WORDS (1024),
        .LATENCY     (LAT),
        .INIT_FILE   ("")
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } expT;

    expT         expQ[$];
    logic [7:0]  bmem [4096];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        forceLow = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        rsp_ready = forceLow ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: byte-addressed memory aliased modulo 4 KiB.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd,
                                  output logic er);
        int ba;
        int ea;
        int n;
        logic ok;
        logic [31:0] w;
        ba = int'(a & 32'hFFF);
        ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
`ifdef DMEM_MISALIGN_TRAP_EN
        if (((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00)) ok = 1'b0;
`endif
        rd = 32'd0;
        er = !ok;
        if (!ok) return;
        case (f3)
            3'd0, 3'd4: begin ea = ba;       n = 1; end
            3'd1, 3'd5: begin ea = ba & ~1;  n = 2; end
            default:    begin ea = ba & ~3;  n = 4; end
        endcase
        if (we) begin
            for (int i = 0; i < n; i++) bmem[ea + i] = wd[8*i +: 8];
            return;
        end
        w = 32'd0;
        for (int i = 0; i < n; i++) w[8*i +: 8] = bmem[ea + i];
        case (f3)
            3'd0:    rd = {{24{w[7]}}, w[7:0]};
            3'd1:    rd = {{16{w[15]}}, w[15:0]};
            default: rd = w;
        endcase
    endfunction

    task automatic doReq(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        int n = 0;
        expT e;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: req_ready stayed 0, expected 1 within 200 cycles");
            req_valid = 1'b0;
            return;
        end
        model(we, f3, a, wd, e.rdata, e.err);
        e.cyc = cyc;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Monitor: pops on each new response, then holds it to the same values until handshake.
    initial begin
        logic pending = 1'b0;
        expT cur;
        forever begin
            @(negedge clk);
            if (rst) begin
                pending = 1'b0;
            end else begin
                if (rsp_valid && !pending) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got rsp_valid 1 expected 0 (no request)");
                    end else begin
                        cur = expQ.pop_front();
                        check32("rsp_rdata", rsp_rdata, cur.rdata);
                        check32("rsp_err", {31'd0, rsp_err}, {31'd0, cur.err});
                        check32("rsp_latency", cyc - cur.cyc, LAT + 1);
                    end
                end else if (rsp_valid) begin
                    check32("hold_rdata", rsp_rdata, cur.rdata);
                    check32("hold_err", {31'd0, rsp_err}, {31'd0, cur.err});
                end
                pending = rsp_valid && !rsp_ready;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check32("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check32("reset_rsp_rdata", rsp_rdata, 32'd0);
        check32("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) doReq(1'b1, 3'd2, 32'(i * 4), $urandom);

        doReq(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        doReq(1'b0, 3'd2, 32'h10, 32'd0);
        doReq(1'b1, 3'd0, 32'h11, 32'h0000007F);
        doReq(1'b0, 3'd0, 32'h11, 32'd0);
        doReq(1'b0, 3'd4, 32'h13, 32'd0);
        doReq(1'b0, 3'd1, 32'h12, 32'd0);

        // Back-pressure: response held for 5 cycles while a second request waits.
        forceLow = 1'b1;
        fork
            begin
                doReq(1'b0, 3'd2, 32'h10, 32'd0);
                doReq(1'b0, 3'd2, 32'h14, 32'd0);
            end
            begin
                n = 0;
                while (!rsp_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                for (int i = 0; i < 5; i++) begin
                    check32("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
                    check32("stall_req_ready", {31'd0, req_ready}, 32'd0);
                    @(negedge clk);
                end
                forceLow = 1'b0;
            end
        join

        doReq(1'b1, 3'd2, 32'h20, 32'hA5A5C3C3);
        // Store dropped by a reset during its first wait cycle.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = 32'h20;
        req_wdata  = 32'h12345678;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check32("rst_drop_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check32("rst_drop_req_ready", {31'd0, req_ready}, 32'd1);
        doReq(1'b0, 3'd2, 32'h20, 32'd0);

        doReq(1'b0, 3'd3, 32'h10, 32'd0);
        doReq(1'b1, 3'd4, 32'h10, 32'h00000055);
        doReq(1'b0, 3'd2, 32'h10, 32'd0);
        doReq(1'b0, 3'd1, 32'h13, 32'd0);

        for (int i = 0; i < 250; i++) begin
            doReq(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63)), $urandom);
        end

        n = 0;
        while ((expQ.size() != 0 || rsp_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d responses outstanding, expected 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
